lsu_mem_adapter: RTL and testbench
==================================

Name: lsu_mem_adapter

Overview:
Load/store adapter between the EX/MEM pipeline stage and the single-port word memory (32-bit, word-addressed, synchronous write on posedge when wEn, combinational read).
- Accepts byte-addressed RISC-V load/store requests through a valid/ready handshake.
- Converts them to word accesses. SB/SH use read-modify-write.
- Returns sign- or zero-extended load data, or an error flag, through a valid/ready response channel.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached memory; must be a power of two, max 2^30.
AW, $clog2(MEM_WORDS), width of the word-address field actually decoded.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  adapter can accept a request.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_rdata  out  32  extended load data; 0 for stores and errors.
rsp_err  out  1  misaligned, out-of-range or illegal funct3.
mem_address  out  32  word address to memory: {zeros, req_addr[AW+1:2]}.
mem_dataIn  out  32  write data to memory.
mem_wEn  out  1  memory write enable.
mem_memOut  in  32  memory read data (combinational).

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset state is IDLE. Reset values: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wEn=0, mem_address=0, mem_dataIn=0.
- Accept rule: a request is accepted on a posedge where req_valid && req_ready. req_ready=1 only in IDLE.
- On accept, the adapter latches we, funct3, addr and wdata. Request inputs are ignored afterwards.
- Error check happens at accept. An error is any of:
  - funct3 not in the legal set. Stores allow only 000/001/010.
  - H/HU with addr[0]≠0.
  - W with addr[1:0]≠0.
  - addr[31:2] ≥ MEM_WORDS.
- On error: go to RESP with rsp_err=1 and rsp_rdata=0. No memory access occurs and mem_wEn stays 0.
- Load (no error): go to READ.
  - READ: drive mem_address and capture mem_memOut into the data register.
  - Then go to RESP.
  - rsp_rdata = selected byte/half (lane chosen by addr[1:0]), sign-extended for B/H and zero-extended for BU/HU; W passes the full word.
- SW (no error): go to WRITE. WRITE drives mem_wEn=1 for exactly one cycle with mem_dataIn=wdata, then goes to RESP.
- SB/SH (no error): go to READ, capture the old word, then go to WRITE.
  - The merged word replaces only the addressed lane(s) with wdata[7:0] or wdata[15:0].
  - Then go to RESP.
- RESP: rsp_valid=1. Outputs are held stable until rsp_ready. On the rsp_valid && rsp_ready posedge, go to IDLE.
- No back-to-back accept in the cycle a response retires; req_ready rises the following cycle.
- Latency from accept edge to rsp_valid high:
  - error: 1 cycle
  - LW/LB/LH: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- mem_wEn is 0 in every state except WRITE. mem_address holds its last value in IDLE.
- Reset mid-operation: return to IDLE next edge. A pending WRITE is abandoned, so mem_wEn is 0 in the reset cycle. Any in-flight response is dropped.
- rsp_ready asserted while rsp_valid=0 has no effect.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding: IDLE, READ, WRITE, RESP
  - function merge_store(old, wdata, funct3, off)
  - function extend_load(word, funct3, off)
- One sub-module, lsu_align_err, is natural: combinational legality/alignment/range check producing err.
- The top-level holds the FSM and datapath registers.

Test Plan:
- Reset, then SW addr=0x10 data=0xDEADBEEF, rsp_ready=1 → mem_wEn high exactly one cycle with mem_address=4 and mem_dataIn=0xDEADBEEF; rsp_valid 2 cycles after accept; rsp_err=0.
- Memory word 4=0x80FF7F01. LB addr=0x13 → rsp_rdata=0xFFFFFF80. LBU addr=0x13 → 0x00000080. LH addr=0x12 → 0xFFFF80FF. LHU addr=0x10 → 0x00007F01. LW addr=0x10 → 0x80FF7F01.
- Word 4=0x11223344. SB addr=0x11 wdata=0xAB → one write of 0x1122AB44, latency 3. Then SH addr=0x12 wdata=0xCDEF → 0xCDEFAB44.
- LW addr=0x12, SH addr=0x11, SB addr=0x80 (MEM_WORDS=32), and load funct3=011 → each gives rsp_err=1 and rsp_rdata=0 one cycle after accept; mem_wEn never asserts.
- Hold rsp_ready=0 for 5 cycles after an LW → rsp_valid and rsp_rdata stay stable and req_ready stays 0; retire on rsp_ready=1; req_ready=1 next cycle.
- Assert rst during WRITE of an SB → mem_wEn=0 in that cycle; next state IDLE, rsp_valid=0, req_ready=1; memory word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store memory adapter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Replace only the addressed byte/half of the old word; W replaces everything.
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] lane;
    case (funct3)
      F3_B: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        lane = 32'(wdata[7:0]) << {off, 3'b000};
      end
      F3_H: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        lane = 32'(wdata[15:0]) << {off[1], 4'b0000};
      end
      default: begin
        mask = '1;
        lane = wdata;
      end
    endcase
    return (old & ~mask) | (lane & mask);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_err.sv
// Combinational request check: illegal funct3, misalignment or address beyond memory.
module lsu_align_err
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        err_c_o
);

  logic illegal;
  logic misal;
  logic range_err;

  always_comb begin
    illegal   = 1'b0;
    misal     = 1'b0;
    case (funct3_i)
      F3_B:    misal = 1'b0;
      F3_H:    misal = addr_i[0];
      F3_W:    misal = |addr_i[1:0];
      F3_BU:   illegal = we_i;
      F3_HU: begin
        illegal = we_i;
        misal   = addr_i[0];
      end
      default: illegal = 1'b1;
    endcase
    // 31-bit compare keeps MEM_WORDS = 2^30 representable.
    range_err = {1'b0, addr_i[31:2]} >= 31'(MEM_WORDS);
    err_c_o   = illegal | misal | range_err;
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter: byte-addressed requests to a single-port word memory,
// read-modify-write for sub-word stores, extended load data on the response.
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  output logic        mem_wEn,
  input  logic [31:0] mem_memOut
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] addr_q;
  logic [31:0] din_q;
  logic        wen_q;
  logic        req_err;

  lsu_align_err #(
    .MEM_WORDS (MEM_WORDS)
  ) u_align_err (
    .we_i     (req_we),
    .funct3_i (req_funct3),
    .addr_i   (req_addr),
    .err_c_o  (req_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      wen_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            ready_q  <= 1'b0;
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              rsp_err_q <= 1'b0;
              addr_q    <= 32'(req_addr[AW+1:2]);
              // Full-word stores skip the read; everything else reads first.
              if (req_we && (req_funct3 == F3_W)) begin
                state_q <= WRITE;
                wen_q   <= 1'b1;
                din_q   <= req_wdata;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          if (we_q) begin
            state_q <= WRITE;
            wen_q   <= 1'b1;
            din_q   <= merge_store(mem_memOut, wdata_q, funct3_q, off_q);
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= extend_load(mem_memOut, funct3_q, off_q);
          end
        end
        WRITE: begin
          state_q     <= RESP;
          wen_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

  // Reset must suppress a pending write on the very edge it is sampled.
  assign mem_wEn     = wen_q & ~rst;
  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_address = addr_q;
  assign mem_dataIn  = din_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Scoreboard bench for lsu_mem_adapter with a behavioural word memory.
module tb_lsu_mem_adapter;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic        mem_wEn;
  logic [31:0] mem_memOut;

  lsu_mem_adapter #(.MEM_WORDS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_dataIn  (mem_dataIn),
    .mem_wEn     (mem_wEn),
    .mem_memOut  (mem_memOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [32];
  int          wen_count = 0;
  logic [31:0] last_wa   = '0;
  logic [31:0] last_wd   = '0;

  assign mem_memOut = mem[mem_address[4:0]];

  always @(posedge clk) begin
    if (mem_wEn) begin
      mem[mem_address[4:0]] <= mem_dataIn;
      wen_count             <= wen_count + 1;
      last_wa               <= mem_address;
      last_wd               <= mem_dataIn;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wens;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wens;
  } vec_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Drive one request, scramble the request bus after accept, wait for and retire the response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                       output logic er, output int wens);
    int wen0;
    int waited;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    wen0       = wen_count;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    wens = wen_count - wen0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_err, mem_wEn} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctrl got rdy/val/err/wen=%b expected 1000",
               {req_ready, rsp_valid, rsp_err, mem_wEn});
    end
    tests++;
    if ({rsp_rdata, mem_address, mem_dataIn} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data got rdata=%h addr=%h din=%h expected all zero",
               rsp_rdata, mem_address, mem_dataIn);
    end
  endtask

  task automatic test_sw();
    int lat; int wens; logic [31:0] rd; logic er; exp_t e;
    exp_q.push_back('{32'h0, 1'b0, 2, 1});
    issue(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, lat, rd, er, wens);
    e = exp_q.pop_front();
    tests++;
    if (lat !== e.lat || wens !== e.wens) begin
      fails++;
      $display("FAIL sw_timing got lat=%0d wens=%0d expected lat=%0d wens=%0d", lat, wens, e.lat, e.wens);
    end
    tests++;
    if (rd !== e.rdata || er !== e.err) begin
      fails++;
      $display("FAIL sw_rsp got rdata=%h err=%b expected rdata=%h err=%b", rd, er, e.rdata, e.err);
    end
    tests++;
    if (last_wa !== 32'd4 || last_wd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL sw_mem got addr=%h data=%h expected addr=00000004 data=deadbeef", last_wa, last_wd);
    end
  endtask

  task automatic test_loads();
    int lat; int wens; logic [31:0] rd; logic er; exp_t e;
    vec_t v[6];
    v[0] = '{1'b1, F3_W,  32'h10, 32'h80FF_7F01, 32'h0,         1'b0, 2, 1};
    v[1] = '{1'b0, F3_B,  32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 0};
    v[2] = '{1'b0, F3_BU, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 2, 0};
    v[3] = '{1'b0, F3_H,  32'h12, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 0};
    v[4] = '{1'b0, F3_HU, 32'h10, 32'h0,         32'h0000_7F01, 1'b0, 2, 0};
    v[5] = '{1'b0, F3_W,  32'h10, 32'h0,         32'h80FF_7F01, 1'b0, 2, 0};
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].lat, v[i].wens});
      issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, er, wens);
      e = exp_q.pop_front();
      tests++;
      if (rd !== e.rdata || er !== e.err) begin
        fails++;
        $display("FAIL load_%0d_rsp got rdata=%h err=%b expected rdata=%h err=%b", i, rd, er, e.rdata, e.err);
      end
      tests++;
      if (lat !== e.lat || wens !== e.wens) begin
        fails++;
        $display("FAIL load_%0d_timing got lat=%0d wens=%0d expected lat=%0d wens=%0d", i, lat, wens, e.lat, e.wens);
      end
    end
  endtask

  task automatic test_subword_store();
    int lat; int wens; logic [31:0] rd; logic er; exp_t e;
    vec_t v[4];
    logic [31:0] wd_exp[4];
    v[0] = '{1'b1, F3_W, 32'h10, 32'h1122_3344, 32'h0,         1'b0, 2, 1};
    v[1] = '{1'b1, F3_B, 32'h11, 32'h0000_00AB, 32'h0,         1'b0, 3, 1};
    v[2] = '{1'b1, F3_H, 32'h12, 32'h0000_CDEF, 32'h0,         1'b0, 3, 1};
    v[3] = '{1'b0, F3_W, 32'h10, 32'h0,         32'hCDEF_AB44, 1'b0, 2, 0};
    wd_exp = '{32'h1122_3344, 32'h1122_AB44, 32'hCDEF_AB44, 32'hCDEF_AB44};
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].lat, v[i].wens});
      issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, er, wens);
      e = exp_q.pop_front();
      tests++;
      if (rd !== e.rdata || er !== e.err) begin
        fails++;
        $display("FAIL rmw_%0d_rsp got rdata=%h err=%b expected rdata=%h err=%b", i, rd, er, e.rdata, e.err);
      end
      tests++;
      if (lat !== e.lat || wens !== e.wens) begin
        fails++;
        $display("FAIL rmw_%0d_timing got lat=%0d wens=%0d expected lat=%0d wens=%0d", i, lat, wens, e.lat, e.wens);
      end
      tests++;
      if (last_wd !== wd_exp[i] || last_wa !== 32'd4) begin
        fails++;
        $display("FAIL rmw_%0d_word got addr=%h data=%h expected addr=00000004 data=%h", i, last_wa, last_wd, wd_exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat; int wens; logic [31:0] rd; logic er; exp_t e;
    vec_t v[5];
    v[0] = '{1'b0, F3_W,   32'h12, 32'h0,         32'h0, 1'b1, 1, 0};
    v[1] = '{1'b1, F3_H,   32'h11, 32'h0000_1234, 32'h0, 1'b1, 1, 0};
    v[2] = '{1'b1, F3_B,   32'h80, 32'h0000_0055, 32'h0, 1'b1, 1, 0};
    v[3] = '{1'b0, 3'b011, 32'h10, 32'h0,         32'h0, 1'b1, 1, 0};
    v[4] = '{1'b1, F3_BU,  32'h10, 32'h0000_0077, 32'h0, 1'b1, 1, 0};
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].lat, v[i].wens});
      issue(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, er, wens);
      e = exp_q.pop_front();
      tests++;
      if (rd !== e.rdata || er !== e.err) begin
        fails++;
        $display("FAIL err_%0d_rsp got rdata=%h err=%b expected rdata=%h err=%b", i, rd, er, e.rdata, e.err);
      end
      tests++;
      if (lat !== e.lat || wens !== e.wens) begin
        fails++;
        $display("FAIL err_%0d_timing got lat=%0d wens=%0d expected lat=%0d wens=%0d", i, lat, wens, e.lat, e.wens);
      end
    end
  endtask

  task automatic test_hold();
    int waited; exp_t e;
    exp_q.push_back('{32'hCDEF_AB44, 1'b0, 2, 0});
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    req_wdata  = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d got val=%b rdata=%h rdy=%b expected val=1 rdata=%h rdy=0",
                 c, rsp_valid, rsp_rdata, req_ready, e.rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_retire got val=%b rdy=%b expected val=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; int wens; logic [31:0] rd; logic er; int wen0; exp_t e;
    issue(1'b1, F3_W, 32'h14, 32'h5566_7788, lat, rd, er, wens);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h14;
    req_wdata  = 32'h0000_0099;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (mem_wEn !== 1'b1) begin
      fails++;
      $display("FAIL rstw_in_write got wen=%b expected wen=1", mem_wEn);
    end
    wen0 = wen_count;
    rst  = 1'b1;
    #1;
    tests++;
    if (mem_wEn !== 1'b0) begin
      fails++;
      $display("FAIL rstw_wen got wen=%b expected wen=0", mem_wEn);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wen_count !== wen0) begin
      fails++;
      $display("FAIL rstw_after got val=%b rdy=%b writes=%0d expected val=0 rdy=1 writes=%0d",
               rsp_valid, req_ready, wen_count, wen0);
    end
    exp_q.push_back('{32'h5566_7788, 1'b0, 2, 0});
    issue(1'b0, F3_W, 32'h14, 32'h0, lat, rd, er, wens);
    e = exp_q.pop_front();
    tests++;
    if (rd !== e.rdata || er !== e.err || lat !== e.lat) begin
      fails++;
      $display("FAIL rstw_word got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
               rd, er, lat, e.rdata, e.err, e.lat);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_sw();
    test_loads();
    test_subword_store();
    test_errors();
    test_hold();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
